// File: rtl/clk_synth_pkg.sv
// clk_synth_pkg: shared types and geometry for the multi-channel clock synthesiser.
// Build option: CLK_SYNTH_SLEW_EN selects gradual integer-divide slewing on retune.
package clk_synth_pkg;

  // Default geometry of the synthesiser
  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W      = 8;
  localparam int FRAC_W     = 4;

  // Width of a channel index, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = clog2_min1(NUM_CH_DEF);

  // Per-channel life cycle
  typedef enum logic [1:0] {
    CS_OFF    = 2'd0,
    CS_SLEW   = 2'd1,
    CS_SETTLE = 2'd2,
    CS_LOCKED = 2'd3
  } cs_state_t;

  // One configuration write as seen by a channel
  typedef struct packed {
    logic [DIV_W-1:0]  div;
    logic [FRAC_W-1:0] frac;
  } ch_cfg_t;

endpackage

// File: rtl/clk_synth_ch.sv
// clk_synth_ch: one fractional-N divider channel with retune FSM and lock counter.
// Build option: CLK_SYNTH_SLEW_EN builds the SLEW state (cur_div walks one step per
// tick toward the target); otherwise a retune loads the new divide at the next tick.
module clk_synth_ch
  import clk_synth_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int LOCK_TICKS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output logic                  tick_o,
  output logic                  clk_o,
  output logic                  locked_o
);

  // One extra counter bit so a period of 2^DIV_WIDTH does not wrap
  localparam int CW = DIV_WIDTH + 1;
  localparam int LW = $clog2(LOCK_TICKS + 1);

  cs_state_t             r_state;
  logic [DIV_WIDTH-1:0]  r_tgt_div;
  logic [DIV_WIDTH-1:0]  r_cur_div;
  logic [FRAC_WIDTH-1:0] r_tgt_frac;
  logic [FRAC_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic [LW-1:0]         r_lock_cnt;
  logic                  r_clk;

  logic [FRAC_WIDTH:0]   w_acc_sum;
  logic                  w_carry;
  logic [CW-1:0]         w_period;
  logic                  w_tick;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_tgt_frac};
  assign w_carry   = w_acc_sum[FRAC_WIDTH];
  assign w_period  = {1'b0, r_cur_div} + CW'(w_carry);
  assign w_tick    = (r_state != CS_OFF) && (r_cnt == (w_period - CW'(1)));

`ifdef CLK_SYNTH_SLEW_EN
  // A write in this cycle steers the slew step taken at a coincident tick
  logic [DIV_WIDTH-1:0] w_goal;
  logic [DIV_WIDTH-1:0] w_step;
  logic [DIV_WIDTH-1:0] w_next_cur;

  assign w_goal = wr_i ? div_i : r_tgt_div;

  // One-step move of cur_div toward the goal
  always_comb begin
    w_step = r_cur_div;
    if (r_cur_div < w_goal) begin
      w_step = r_cur_div + DIV_WIDTH'(1);
    end else if (r_cur_div > w_goal) begin
      w_step = r_cur_div - DIV_WIDTH'(1);
    end
  end

  assign w_next_cur = w_tick ? w_step : r_cur_div;
`endif

  // Period counter, fractional accumulator, output clock and retune FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= CS_OFF;
      r_tgt_div  <= '0;
      r_tgt_frac <= '0;
      r_cur_div  <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_lock_cnt <= '0;
      r_clk      <= 1'b0;
    end else if (wr_i && (div_i == '0)) begin
      // Disable wins over everything, including a coincident tick
      r_state    <= CS_OFF;
      r_tgt_div  <= '0;
      r_tgt_frac <= '0;
      r_cur_div  <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_lock_cnt <= '0;
      r_clk      <= 1'b0;
    end else if (wr_i && (r_state == CS_OFF)) begin
      // Cold start: jump straight to the requested divide
      r_state    <= CS_SETTLE;
      r_tgt_div  <= div_i;
      r_tgt_frac <= frac_i;
      r_cur_div  <= div_i;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_lock_cnt <= '0;
    end else if (r_state != CS_OFF) begin
      if (w_tick) begin
        r_cnt <= '0;
        r_acc <= w_acc_sum[FRAC_WIDTH-1:0];
        r_clk <= ~r_clk;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (wr_i) begin
        r_tgt_div  <= div_i;
        r_tgt_frac <= frac_i;
        r_lock_cnt <= '0;
      end
`ifdef CLK_SYNTH_SLEW_EN
      if (wr_i) begin
        if (w_tick) begin
          r_cur_div <= w_step;
        end
        r_state <= (w_next_cur == div_i) ? CS_SETTLE : CS_SLEW;
      end else if (w_tick) begin
        case (r_state)
          CS_SLEW: begin
            r_cur_div <= w_step;
            if (w_step == r_tgt_div) begin
              r_state    <= CS_SETTLE;
              r_lock_cnt <= '0;
            end
          end
          CS_SETTLE: begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
            if (r_lock_cnt == LW'(LOCK_TICKS - 1)) begin
              r_state <= CS_LOCKED;
            end
          end
          default: ;
        endcase
      end
`else
      if (wr_i) begin
        r_state <= CS_SETTLE;
        if (w_tick) begin
          r_cur_div <= div_i;
        end
      end else if (w_tick && (r_state == CS_SETTLE)) begin
        // The tick that loads a pending divide does not count toward lock
        if (r_cur_div != r_tgt_div) begin
          r_cur_div  <= r_tgt_div;
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + LW'(1);
          if (r_lock_cnt == LW'(LOCK_TICKS - 1)) begin
            r_state <= CS_LOCKED;
          end
        end
      end
`endif
    end
  end

  assign tick_o   = w_tick;
  assign clk_o    = r_clk;
  assign locked_o = (r_state == CS_LOCKED);

endmodule

// File: rtl/clk_synth_multi.sv
// clk_synth_multi: NUM_CH fractional-N clock synthesiser channels behind one
// configuration write port. Build option: CLK_SYNTH_SLEW_EN (gradual retune slewing).
module clk_synth_multi
  import clk_synth_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DIV_WIDTH  = DIV_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int LOCK_TICKS = 16,
  localparam int CFG_CH_W  = (NUM_CH == NUM_CH_DEF) ? CH_W : clog2_min1(NUM_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CFG_CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [FRAC_WIDTH-1:0] cfg_frac_i,
  output logic                  cfg_err_o,
  output logic [NUM_CH-1:0]     tick_o,
  output logic [NUM_CH-1:0]     clk_o,
  output logic [NUM_CH-1:0]     locked_o
);

  logic    w_accept;
  logic    w_ch_bad;
  logic    r_cfg_err;
  ch_cfg_t w_cfg;

  // No back-pressure: writes are only refused while reset is held
  assign cfg_ready_o = ~rst_i;
  assign w_accept    = cfg_valid_i & ~rst_i;
  assign w_ch_bad    = ({1'b0, cfg_ch_i} >= (CFG_CH_W + 1)'(NUM_CH));
  assign w_cfg.div   = cfg_div_i;
  assign w_cfg.frac  = cfg_frac_i;

  // Flag writes that name a channel that does not exist
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept & w_ch_bad;
    end
  end

  assign cfg_err_o = r_cfg_err;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_wr;

      assign w_wr = w_accept & ~w_ch_bad & (cfg_ch_i == CFG_CH_W'(gi));

      clk_synth_ch #(
        .DIV_WIDTH  (DIV_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .LOCK_TICKS (LOCK_TICKS)
      ) u_ch (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_i     (w_wr),
        .div_i    (w_cfg.div),
        .frac_i   (w_cfg.frac),
        .tick_o   (tick_o[gi]),
        .clk_o    (clk_o[gi]),
        .locked_o (locked_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_synth_multi.sv
// tb_clk_synth_multi: randomized and directed checks of clk_synth_multi against an
// arithmetic model of tick times (tick k lands k*div + floor(k*frac/2^F) cycles after
// the start write). A second 3-channel instance exercises the invalid-channel path.
module tb_clk_synth_multi;

  localparam int FW = 4;
  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic       ready;
  logic       err;
  logic [1:0] ch = '0;
  logic [7:0] dv = '0;
  logic [3:0] fr = '0;
  logic [3:0] tick;
  logic [3:0] cko;
  logic [3:0] lk;

  logic       v3 = 1'b0;
  logic       ready3;
  logic       err3;
  logic [1:0] ch3 = '0;
  logic [7:0] dv3 = '0;
  logic [3:0] fr3 = '0;
  logic [2:0] tick3;
  logic [2:0] cko3;
  logic [2:0] lk3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_synth_multi #(.NUM_CH(4), .DIV_WIDTH(8), .FRAC_WIDTH(4), .LOCK_TICKS(LT)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(v), .cfg_ready_o(ready), .cfg_ch_i(ch),
    .cfg_div_i(dv), .cfg_frac_i(fr), .cfg_err_o(err), .tick_o(tick), .clk_o(cko),
    .locked_o(lk)
  );

  clk_synth_multi #(.NUM_CH(3), .DIV_WIDTH(8), .FRAC_WIDTH(4), .LOCK_TICKS(LT)) dut3 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(v3), .cfg_ready_o(ready3), .cfg_ch_i(ch3),
    .cfg_div_i(dv3), .cfg_frac_i(fr3), .cfg_err_o(err3), .tick_o(tick3), .clk_o(cko3),
    .locked_o(lk3)
  );

  // Cycle (counted from the start write) at which tick k of a steady channel fires
  function automatic int tick_time(input int k, input int d, input int f);
    return k * d + ((k * f) >> FW);
  endfunction

  // Number of ticks a steady channel has produced up to and including cycle n
  function automatic int ticks_upto(input int n, input int d, input int f);
    int k = 0;
    while (tick_time(k + 1, d, f) <= n) k++;
    return k;
  endfunction

  task automatic wr(input int c, input int d, input int f);
    @(negedge clk);
    v = 1'b1; ch = c[1:0]; dv = d[7:0]; fr = f[3:0];
    @(posedge clk);
    #1 v = 1'b0;
    $display("WR ch=%0d div=%0d frac=%0d t=%0t", c, d, f, $time);
  endtask

  task automatic wr3(input int c, input int d, input int f);
    @(negedge clk);
    v3 = 1'b1; ch3 = c[1:0]; dv3 = d[7:0]; fr3 = f[3:0];
    @(posedge clk);
    #1 v3 = 1'b0;
    $display("WR3 ch=%0d div=%0d frac=%0d t=%0t", c, d, f, $time);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tick, cko, lk, err, ready} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outs tick=%b clk=%b lock=%b err=%b ready=%b exp all 0",
               tick, cko, lk, err, ready);
    end
    checks++;
    if ({tick3, cko3, lk3, err3, ready3} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs3 got %b exp 0", {tick3, cko3, lk3, err3, ready3});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tick !== 4'd0) begin
      errors++;
      $display("FAIL reset_release ready=%b tick=%b exp 1/0000", ready, tick);
    end
  endtask

  task automatic test_div4();
    int t;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      t = ticks_upto(n - 1, 4, 0);
      checks += 3;
      if (tick[0] !== (ticks_upto(n, 4, 0) != t)) begin
        errors++;
        $display("FAIL div4_tick n=%0d got %b exp %b", n, tick[0], ticks_upto(n, 4, 0) != t);
      end
      if (cko[0] !== t[0]) begin
        errors++;
        $display("FAIL div4_clk n=%0d got %b exp %b", n, cko[0], t[0]);
      end
      if (lk[0] !== (t >= LT)) begin
        errors++;
        $display("FAIL div4_lock n=%0d got %b exp %b", n, lk[0], t >= LT);
      end
    end
  endtask

  task automatic test_frac();
    int t;
    int cnt = 0;
    int last = 0;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      t = ticks_upto(n - 1, 3, 8);
      if (tick[1] === 1'b1 && n <= 112) begin
        cnt++;
        last = n;
      end
      checks += 3;
      if (tick[1] !== (ticks_upto(n, 3, 8) != t)) begin
        errors++;
        $display("FAIL frac_tick n=%0d got %b exp %b", n, tick[1], ticks_upto(n, 3, 8) != t);
      end
      if (cko[1] !== t[0]) begin
        errors++;
        $display("FAIL frac_clk n=%0d got %b exp %b", n, cko[1], t[0]);
      end
      if (lk[1] !== (t >= LT)) begin
        errors++;
        $display("FAIL frac_lock n=%0d got %b exp %b", n, lk[1], t >= LT);
      end
    end
    checks += 2;
    if (cnt != 32) begin
      errors++;
      $display("FAIL frac_count got %0d exp 32", cnt);
    end
    if (last != 112) begin
      errors++;
      $display("FAIL frac_last got %0d exp 112", last);
    end
  endtask

  task automatic test_random();
    int d [2];
    int f [2];
    int n;
    int t;
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 2; i++) begin
        d[i] = int'($urandom_range(1, 12));
        f[i] = int'($urandom_range(0, 15));
      end
      wr(2, 0, 0);
      wr(3, 0, 0);
      wr(2, d[0], f[0]);
      wr(3, d[1], f[1]);
      for (int m = 1; m <= 230; m++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          n = (i == 0) ? m + 1 : m;
          t = ticks_upto(n - 1, d[i], f[i]);
          checks += 3;
          if (tick[2+i] !== (ticks_upto(n, d[i], f[i]) != t)) begin
            errors++;
            $display("FAIL rand_tick ch=%0d div=%0d frac=%0d n=%0d got %b exp %b",
                     2 + i, d[i], f[i], n, tick[2+i], ticks_upto(n, d[i], f[i]) != t);
          end
          if (cko[2+i] !== t[0]) begin
            errors++;
            $display("FAIL rand_clk ch=%0d n=%0d got %b exp %b", 2 + i, n, cko[2+i], t[0]);
          end
          if (lk[2+i] !== (t >= LT)) begin
            errors++;
            $display("FAIL rand_lock ch=%0d n=%0d got %b exp %b", 2 + i, n, lk[2+i], t >= LT);
          end
        end
      end
    end
  endtask

  task automatic test_retune();
    int q[$];
    int tt;
    int seen;
    int idx;
    int lock_after;
    logic e_tick;
    wr(2, 0, 0);
    wr(2, 5, 0);
    repeat (81) @(negedge clk);
    checks++;
    if (lk[2] !== 1'b1) begin
      errors++;
      $display("FAIL retune_prelock got %b exp 1", lk[2]);
    end
    wr(2, 9, 0);
    // The running period of 5 finishes two cycles after the retune write
    tt = 3;
    q.push_back(tt);
`ifdef CLK_SYNTH_SLEW_EN
    for (int p = 6; p <= 8; p++) begin
      tt += p;
      q.push_back(tt);
    end
    lock_after = 4 + LT;
`else
    lock_after = 1 + LT;
`endif
    while (tt < 200) begin
      tt += 9;
      q.push_back(tt);
    end
    seen = 0;
    idx = 0;
    for (int m = 1; m <= 175; m++) begin
      @(negedge clk);
      e_tick = (q[idx] == m);
      checks += 3;
      if (tick[2] !== e_tick) begin
        errors++;
        $display("FAIL retune_tick m=%0d got %b exp %b", m, tick[2], e_tick);
      end
      if (cko[2] !== seen[0]) begin
        errors++;
        $display("FAIL retune_clk m=%0d got %b exp %b", m, cko[2], seen[0]);
      end
      if (lk[2] !== (seen >= lock_after)) begin
        errors++;
        $display("FAIL retune_lock m=%0d got %b exp %b", m, lk[2], seen >= lock_after);
      end
      if (e_tick) begin
        seen++;
        idx++;
      end
    end
  endtask

  task automatic test_div1();
    int t;
    wr(0, 0, 0);
    wr(0, 1, 0);
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      t = ticks_upto(m - 1, 1, 0);
      checks += 3;
      if (tick[0] !== 1'b1) begin
        errors++;
        $display("FAIL div1_tick m=%0d got %b exp 1", m, tick[0]);
      end
      if (cko[0] !== t[0]) begin
        errors++;
        $display("FAIL div1_clk m=%0d got %b exp %b", m, cko[0], t[0]);
      end
      if (lk[0] !== (t >= LT)) begin
        errors++;
        $display("FAIL div1_lock m=%0d got %b exp %b", m, lk[0], t >= LT);
      end
    end
    wr(0, 0, 0);
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      checks++;
      if ({tick[0], cko[0], lk[0]} !== 3'b000) begin
        errors++;
        $display("FAIL div0_off m=%0d tick/clk/lock=%b exp 000", m, {tick[0], cko[0], lk[0]});
      end
    end
  endtask

  task automatic test_bad_ch();
    wr3(0, 2, 0);
    wr3(3, 5, 0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      checks += 4;
      if (err3 !== (j == 1)) begin
        errors++;
        $display("FAIL badch_err j=%0d got %b exp %b", j, err3, j == 1);
      end
      if (tick3[0] !== ((j + 1) % 2 == 0)) begin
        errors++;
        $display("FAIL badch_ch0 j=%0d got %b exp %b", j, tick3[0], (j + 1) % 2 == 0);
      end
      if ({tick3[2:1], cko3[2:1], lk3} !== 7'd0) begin
        errors++;
        $display("FAIL badch_others j=%0d got %b exp 0", j, {tick3[2:1], cko3[2:1], lk3});
      end
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL badch_err4 j=%0d got %b exp 0", j, err);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      wr(c, 0, 0);
      wr(c, 1, 0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (lk !== 4'hF) begin
      errors++;
      $display("FAIL midrst_prelock got %b exp 1111", lk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tick, cko, lk, err, ready} !== 14'd0 || {tick3, cko3, lk3, ready3} !== 10'd0) begin
      errors++;
      $display("FAIL midrst_outs tick=%b clk=%b lock=%b err=%b ready=%b exp all 0",
               tick, cko, lk, err, ready);
    end
    rst = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      checks++;
      if ({tick, cko, lk} !== 12'd0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after m=%0d tick=%b clk=%b lock=%b ready=%b exp 0/0/0/1",
                 m, tick, cko, lk, ready);
      end
    end
  endtask

  initial begin
    test_reset();
    wr(0, 4, 0);
    test_div4();
    wr(1, 3, 8);
    test_frac();
    test_random();
    test_retune();
    test_div1();
    test_bad_ch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
